data_delay_prog: RTL and testbench
==================================

# data_delay_prog

Parametrised multi-channel programmable delay line. Delays NCH parallel samples of BITS each by a runtime-selected number of valid input samples (1..MAX_DELAY), with valid qualification, flush-on-reprogram and clamping of illegal delays. Successor of the fixed-depth data delay in the unit-1 datapath; sits between the sample source and the downstream scaler/filter stages.

## Interface
- BITS, 16, sample width per channel
- NCH, 2, number of channels delayed in lock-step
- MAX_DELAY, 8, maximum delay in samples (≥2)
- DEFAULT_DELAY, 4, delay loaded at reset (1..MAX_DELAY)
- DW, $clog2(MAX_DELAY+1), delay/fill counter width (derived, not overridden)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_valid  in  1  input sample strobe
- i_data  in  NCH*BITS  input samples, channel c at [c*BITS +: BITS]
- i_load  in  1  one-cycle strobe: latch i_delay
- i_delay  in  DW  requested delay, sampled when i_load=1
- o_valid  out  1  output sample strobe
- o_data  out  NCH*BITS  delayed samples, same channel packing
- o_delay  out  DW  active (clamped) delay
- o_full  out  1  fill counter ≥ active delay

## Operation
- Storage: shift chain sr[0..MAX_DELAY-1], each NCH*BITS. Advances only when i_valid=1: sr[0]<=i_data, sr[k]<=sr[k-1]. Holds otherwise.
- Output: when i_valid=1, o_data<=sr[d-1] (sample d valid inputs ago, pre-shift value), o_valid<=(fill≥d). When i_valid=0, o_valid<=0, o_data holds.
- Fill counter: +1 per i_valid, saturates at MAX_DELAY.
- Delay load: i_load=1 -> d<=clamp(i_delay); 0 clamps to 1, >MAX_DELAY clamps to MAX_DELAY. Fill cleared (flush): contents kept but not trusted.
- i_load and i_valid same cycle: new d takes effect, sample shifts in, fill<=1, o_valid<=0.
- o_full = (fill≥d), registered-path derived, combinational from state.
- All channels share d, fill and valid; no per-channel state.

## Timing
- Reset (i_rst=0 at edge): sr all 0, fill 0, d=DEFAULT_DELAY, o_valid 0, o_data 0, o_delay DEFAULT_DELAY, o_full 0. Reset mid-stream discards all pending samples.
- Latency: one clock from the i_valid edge to o_valid; the output carries input from d valid samples earlier.
- First o_valid after reset/load: on the (d+1)-th i_valid after it (load cycle sample counts as first).
- Gaps in i_valid do not age data; delay is in samples, not cycles.
- o_delay updates the cycle after i_load.
- Fill saturation at MAX_DELAY: no wrap; o_valid stays valid indefinitely.

## Configuration
- DATA_DELAY_TAPS_EN defined: extra port o_taps out MAX_DELAY*NCH*BITS, flat copy of sr (stage k at [k*NCH*BITS +: NCH*BITS]), updated with the chain, reset to 0; for FIR/debug use.
- Undefined: port absent, no extra logic; core behaviour identical.

## Structure
- Package data_delay_pkg: clamp function for delay, default parameter constants, channel slice helper (c, BITS) -> offset.
- Sub-module data_delay_mux: MAX_DELAY:1 word mux selecting sr[d-1]; core holds chain, counters, control.

## Test plan
- Reset, NCH=2, d=4, i_valid every cycle, ch0 = 1,2,3,...,ch1 = 101,102,... -> first o_valid after 5th input with o_data={101,1}; then successive +1.
- i_valid toggling 1/0 with same data -> outputs identical to continuous case, o_valid only cycles after valid inputs.
- i_load i_delay=0 -> o_delay=1, next valid input echoes previous one; i_load i_delay=15 (MAX 8) -> o_delay=8.
- Steady stream at d=4, then i_load d=2 concurrent with i_valid -> o_valid low that cycle and next, resumes on 3rd valid after load with 2-sample delay.
- Reset asserted mid-stream for one edge -> o_valid 0, o_data 0, o_delay=4; restart behaves as first scenario.
- With DATA_DELAY_TAPS_EN, feed 1..8 at MAX_DELAY=8 -> o_taps stage k = 8-k.

Source files
------------

// File: rtl/data_delay_pkg.sv
// Shared constants and helpers for the programmable multi-channel delay line.
// Optional feature macro used by the top level: DATA_DELAY_TAPS_EN.
package data_delay_pkg;

    localparam int DEF_BITS          = 16;
    localparam int DEF_NCH           = 2;
    localparam int DEF_MAX_DELAY     = 8;
    localparam int DEF_DEFAULT_DELAY = 4;

    // Force a requested delay into the legal range 1..max_d.
    function automatic int clamp_delay(input int req, input int max_d);
        if (req < 1) begin
            return 1;
        end
        if (req > max_d) begin
            return max_d;
        end
        return req;
    endfunction

    // Bit offset of channel c inside a packed multi-channel word.
    function automatic int chan_offset(input int c, input int bits);
        return c * bits;
    endfunction

endpackage

// File: rtl/data_delay_mux.sv
// Word selector for the delay chain: returns stage (sel-1) of the flat chain.
// sel is a delay in samples, always 1..DEPTH when driven by the core.
module data_delay_mux #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int DW    = 4
) (
    input  logic [DEPTH*W-1:0] words,
    input  logic [DW-1:0]      sel,
    output logic [W-1:0]       word
);

    logic [W-1:0] stage [DEPTH];

    // Unpack the flat chain into addressable stages.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
            assign stage[gi] = words[gi*W +: W];
        end
    endgenerate

    // One-hot compare on the delay value; out-of-range selects give zero.
    always_comb begin
        word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == DW'(k + 1)) begin
                word = stage[k];
            end
        end
    end

endmodule

// File: rtl/data_delay_prog.sv
// Programmable multi-channel delay line: delays NCH samples of BITS each by a
// runtime-selected number of valid samples (1..MAX_DELAY).
// Define DATA_DELAY_TAPS_EN to expose the whole chain on o_taps.
module data_delay_prog
    import data_delay_pkg::*;
#(
    parameter int  BITS          = DEF_BITS,
    parameter int  NCH           = DEF_NCH,
    parameter int  MAX_DELAY     = DEF_MAX_DELAY,
    parameter int  DEFAULT_DELAY = DEF_DEFAULT_DELAY,
    localparam int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [NCH*BITS-1:0] i_data,
    input  logic                i_load,
    input  logic [DW-1:0]       i_delay,
    output logic                o_valid,
    output logic [NCH*BITS-1:0] o_data,
    output logic [DW-1:0]       o_delay,
    output logic                o_full
`ifdef DATA_DELAY_TAPS_EN
    ,
    output logic [MAX_DELAY*NCH*BITS-1:0] o_taps
`endif
);

    localparam int W = NCH * BITS;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] RST_D = DW'(clamp_delay(DEFAULT_DELAY, MAX_DELAY));

    logic [W-1:0]           sr_reg [MAX_DELAY];
    logic [MAX_DELAY*W-1:0] sr_flat;
    logic [DW-1:0]          d_reg;
    logic [DW-1:0]          fill_reg;
    logic [DW-1:0]          load_d;
    logic [DW-1:0]          d_sel;
    logic [W-1:0]           tap_word;
    logic                   o_valid_reg;
    logic [W-1:0]           o_data_reg;

    // A load takes effect in the same cycle as a concurrent sample, so the
    // output tap is chosen from the new delay when i_load is high.
    assign load_d = DW'(clamp_delay(int'(i_delay), MAX_DELAY));
    assign d_sel  = i_load ? load_d : d_reg;

    generate
        for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_flat
            assign sr_flat[gi*W +: W] = sr_reg[gi];
        end
    endgenerate

    data_delay_mux #(
        .W    (W),
        .DEPTH(MAX_DELAY),
        .DW   (DW)
    ) u_mux (
        .words(sr_flat),
        .sel  (d_sel),
        .word (tap_word)
    );

    // Shift chain advances only on valid samples, so gaps do not age data.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                sr_reg[k] <= '0;
            end
        end else if (i_valid) begin
            sr_reg[0] <= i_data;
            for (int k = 1; k < MAX_DELAY; k++) begin
                sr_reg[k] <= sr_reg[k-1];
            end
        end
    end

    // Active delay and fill counter; a load flushes trust in the chain contents.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            d_reg    <= RST_D;
            fill_reg <= '0;
        end else if (i_load) begin
            d_reg    <= load_d;
            fill_reg <= i_valid ? DW'(1) : '0;
        end else if (i_valid && (fill_reg != MAX_D)) begin
            fill_reg <= fill_reg + 1'b1;
        end
    end

    // Registered outputs: one clock after each valid input, hold data in gaps.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
        end else begin
            o_valid_reg <= i_valid && !i_load && (fill_reg >= d_reg);
            if (i_valid) begin
                o_data_reg <= tap_word;
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_data  = o_data_reg;
    assign o_delay = d_reg;
    assign o_full  = (fill_reg >= d_reg);

`ifdef DATA_DELAY_TAPS_EN
    assign o_taps = sr_flat;
`endif

endmodule

// File: tb/tb_data_delay_prog.sv
// Self-checking bench for data_delay_prog: directed scenarios plus a random
// phase, compared against a sample-history reference model.
module tb_data_delay_prog;
    import data_delay_pkg::*;

    localparam int BITS = 16;
    localparam int NCH  = 2;
    localparam int MAXD = 8;
    localparam int DEFD = 4;
    localparam int DW   = $clog2(MAXD + 1);
    localparam int W    = NCH * BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [W-1:0]  din;
    logic          load;
    logic [DW-1:0] dly;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [DW-1:0] o_delay;
    logic          o_full;
`ifdef DATA_DELAY_TAPS_EN
    logic [MAXD*W-1:0] o_taps;
`endif

    always #5 clk = ~clk;

    data_delay_prog #(
        .BITS(BITS), .NCH(NCH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(valid),
        .i_data (din),
        .i_load (load),
        .i_delay(dly),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_delay(o_delay),
        .o_full (o_full)
`ifdef DATA_DELAY_TAPS_EN
        ,
        .o_taps (o_taps)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: history of accepted samples (newest at index 0),
    // number of samples accepted since the last flush, and the active delay.
    logic [W-1:0] hist [MAXD];
    int           cnt_m;
    int           d_m;
    logic         ov_m;
    logic [W-1:0] od_m;

    function automatic logic [W-1:0] pack(input int c0, input int c1);
        logic [W-1:0] w;
        w = '0;
        w[chan_offset(0, BITS) +: BITS] = BITS'(c0);
        w[chan_offset(1, BITS) +: BITS] = BITS'(c1);
        return w;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic l, input logic [W-1:0] dat,
                              input logic [DW-1:0] dl);
        int nd;
        if (!r) begin
            for (int i = 0; i < MAXD; i++) hist[i] = '0;
            cnt_m = 0;
            d_m   = DEFD;
            ov_m  = 1'b0;
            od_m  = '0;
            return;
        end
        nd = d_m;
        if (l) begin
            nd = int'(dl);
            if (nd < 1) nd = 1;
            if (nd > MAXD) nd = MAXD;
        end
        if (v) begin
            // Output is the sample nd accepted inputs ago, trusted only once
            // that many samples have arrived since the last flush.
            ov_m = !l && (cnt_m >= d_m);
            od_m = hist[nd-1];
            for (int i = MAXD - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = dat;
            cnt_m = l ? 1 : ((cnt_m + 1 > MAXD) ? MAXD : cnt_m + 1);
        end else begin
            ov_m = 1'b0;
            if (l) cnt_m = 0;
        end
        d_m = nd;
    endtask

    task automatic cycle(input logic r, input logic v, input logic l, input logic [W-1:0] dat,
                         input logic [DW-1:0] dl);
        rst = r; valid = v; load = l; din = dat; dly = dl;
        @(posedge clk);
        model_edge(r, v, l, dat, dl);
        #1;
        check_eq("o_valid", W'(o_valid), W'(ov_m));
        check_eq("o_data", o_data, od_m);
        check_eq("o_delay", W'(o_delay), W'(d_m));
        check_eq("o_full", W'(o_full), W'(cnt_m >= d_m));
        $display("txn rst=%0b v=%0b ld=%0b dly=%0d din=%h -> ov=%0b od=%h d=%0d full=%0b",
                 r, v, l, dl, dat, o_valid, o_data, o_delay, o_full);
        rst = 1'b1; valid = 1'b0; load = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        check_eq("rst_delay", W'(o_delay), W'(DEFD));
        check_eq("rst_valid", W'(o_valid), '0);
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; load = 1'b0; din = '0; dly = '0;
        cnt_m = 0; d_m = DEFD; ov_m = 1'b0; od_m = '0;
        for (int i = 0; i < MAXD; i++) hist[i] = '0;

        // Continuous stream at default delay 4.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, pack(i, 100 + i), '0);
            if (i == 4) check_eq("pre_first_valid", W'(o_valid), '0);
            if (i == 5) check_eq("first_out", o_data, {16'd101, 16'd1});
            if (i == 6) check_eq("second_out", o_data, {16'd102, 16'd2});
        end

        // Valid toggling: gaps must not age data.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, pack(i, 100 + i), '0);
            cycle(1'b1, 1'b0, 1'b0, '0, '0);
        end

        // Delay clamping.
        cycle(1'b1, 1'b0, 1'b1, '0, DW'(0));
        check_eq("clamp_low", W'(o_delay), W'(1));
        cycle(1'b1, 1'b1, 1'b0, pack(50, 150), '0);
        cycle(1'b1, 1'b1, 1'b0, pack(51, 151), '0);
        cycle(1'b1, 1'b1, 1'b0, pack(52, 152), '0);
        check_eq("echo_prev", o_data, pack(51, 151));
        cycle(1'b1, 1'b0, 1'b1, '0, DW'(15));
        check_eq("clamp_high", W'(o_delay), W'(MAXD));

        // Reprogram from 4 to 2 concurrent with a valid sample.
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, pack(i, 100 + i), '0);
        cycle(1'b1, 1'b1, 1'b1, pack(9, 109), DW'(2));
        check_eq("load_cycle_valid", W'(o_valid), '0);
        cycle(1'b1, 1'b1, 1'b0, pack(10, 110), '0);
        check_eq("load_next_valid", W'(o_valid), '0);
        cycle(1'b1, 1'b1, 1'b0, pack(11, 111), '0);
        check_eq("load_resume", o_data, pack(9, 109));

        // Mid-stream reset then restart.
        cycle(1'b0, 1'b1, 1'b0, pack(77, 177), '0);
        check_eq("midrst_valid", W'(o_valid), '0);
        check_eq("midrst_data", o_data, '0);
        check_eq("midrst_delay", W'(o_delay), W'(DEFD));
        for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b1, 1'b0, pack(i, 100 + i), '0);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            logic r, v, l;
            r = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 19) == 0);
            cycle(r, v, l, W'($urandom), DW'($urandom_range(0, 15)));
        end

`ifdef DATA_DELAY_TAPS_EN
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, '0, DW'(MAXD));
        for (int i = 1; i <= MAXD; i++) cycle(1'b1, 1'b1, 1'b0, pack(i, 100 + i), '0);
        for (int k = 0; k < MAXD; k++) begin
            check_eq("tap_stage", o_taps[k*W +: W], pack(MAXD - k, 100 + MAXD - k));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
